uart_tx_sched: RTL

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte producers. Each requester offers a byte with a valid/ready handshake. The scheduler grants one requester at a time and issues a one-cycle `tx_start` with the captured byte. It then tracks the transmitter's `tx_busy` through the whole frame and signals per-requester completion. It sits between the producers and `uart_tx`, in the same clock domain.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_sched_if.sv | 25 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit scheduler.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int SCHED_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshake plus transmitter control bundle for uart_tx_sched.
interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]             req_valid;
  logic [UART_DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             req_done;
  logic                         tx_start;
  logic [UART_DATA_W-1:0]       tx_data;
  logic                         tx_busy;

  // master: producers and transmitter side; slave: the scheduler
  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, req_done, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, req_done, tx_start, tx_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request after 'last', wrapping.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W-1:0] j;
    logic             found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IDX_W'((int'(last) + k) % N);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte producers, one frame per grant.
//
//   state     | meaning
//   IDLE      | searching round-robin for a valid requester, tx must be free
//   START     | one-cycle tx_start with the captured byte
//   WAIT_ACK  | waiting for tx_busy to rise, bounded by ACK_TIMEOUT
//   WAIT_DONE | frame on the wire, waiting for tx_busy to fall
//   GAP       | GAP_CLKS+1 cycles of spacing before the next grant
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int GAP_CLKS    = 0,
  parameter  int ACK_TIMEOUT = 15,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_sched_if.slave   bus,
  output logic [IDX_W-1:0] grant_id,
  output logic             sched_busy,
  output logic             ack_err
);

  localparam logic [SCHED_CNT_W-1:0] ACK_LAST = SCHED_CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [SCHED_CNT_W-1:0] GAP_LAST = SCHED_CNT_W'(GAP_CLKS);

  sched_state_t           state, state_nxt;
  logic [SCHED_CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]       last_grant;
  logic [N_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic [N_REQ-1:0]       ready;
  logic [N_REQ-1:0]       done_q;
  logic [UART_DATA_W-1:0] data_q;
  logic                   take, done_set, ack_set, start;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req  (bus.req_valid),
    .last (last_grant),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = '0;
    take      = 1'b0;
    done_set  = 1'b0;
    ack_set   = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.tx_busy && (|bus.req_valid)) begin
          ready     = arb_gnt;
          take      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        start     = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == ACK_LAST) begin
          // byte is dropped; the grant still counts for round-robin order
          ack_set   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + SCHED_CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_set  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt >= GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + SCHED_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      grant_id   <= '0;
      data_q     <= '0;
      done_q     <= '0;
      ack_err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_set ? (N_REQ'(1) << grant_id) : '0;
      if (take) begin
        last_grant <= arb_idx;
        grant_id   <= arb_idx;
        data_q     <= bus.req_data[UART_DATA_W*arb_idx +: UART_DATA_W];
      end
      if (ack_set) ack_err <= 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign bus.req_done  = done_q;
  assign bus.tx_start  = start;
  assign bus.tx_data   = data_q;
  assign sched_busy    = (state != IDLE);

endmodule
